pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Program counter and instruction-fetch stage for the single-cycle MIPS core.
//   - Holds the PC and fetches each instruction over a req/ack instruction-memory port.
//   - Presents the instruction to Control_Unit for exactly one execute cycle.
//   - Computes next PC from the pcsource code the decoder produces.
//   - Flags fetch timeouts (and, optionally, misaligned targets) as a sticky error.
// PARAMETERS
//   RESET_PC       32'h0000_0000  PC value loaded on reset
//   FETCH_TIMEOUT  16             max FETCH cycles without imem_ack before error (>=1)
// PORTS
//   clk         in   1   system clock, rising edge
//   rst         in   1   synchronous, active-high reset
//   pcsource    in   2   next-PC select from Control_Unit: 00 seq, 01 branch, 10 jr, 11 j/jal
//   ra_data     in   32  register rs value (jr target)
//   imem_req    out  1   fetch request, held until imem_ack
//   imem_addr   out  32  fetch address (= pc while imem_req)
//   imem_rdata  in   32  fetched instruction word, valid with imem_ack
//   imem_ack    in   1   fetch complete; honoured only in FETCH
//   inst        out  32  instruction register, feeds op/func/imm decode
//   inst_valid  out  1   execute strobe; gates wreg/wmem downstream
//   pc          out  32  current PC
//   pc_plus4    out  32  pc + 4, combinational (jal link value)
//   fetch_err   out  1   sticky error flag
// BEHAVIOUR
//   Reset values: pc=RESET_PC, inst=0, inst_valid=0, imem_req=0, fetch_err=0, state=IDLE, tcnt=0.
//   States:
//     IDLE  -> FETCH unconditionally; one cycle after reset release.
//     FETCH -> imem_req=1, imem_addr=pc, stable until ack.
//              On ack: inst<=imem_rdata, go EXEC.
//              Else if tcnt==FETCH_TIMEOUT-1: go ERROR, fetch_err<=1.
//              Else tcnt++.
//              Ack in the same cycle as the limit: ack wins.
//              tcnt clears on every entry to FETCH.
//     EXEC  -> inst_valid=1 for exactly this one cycle; imem_req=0.
//              pcsource and ra_data sampled this cycle; pc<=next_pc; go FETCH.
//     ERROR -> imem_req=0, inst_valid=0, pc/inst frozen; sticky until rst.
//   next_pc (all arithmetic modulo 2^32, overflow wraps silently):
//     00: pc+4
//     01: pc+4 + (sext(inst[15:0]) << 2)
//     10: ra_data
//     11: {pc_plus4[31:28], inst[25:0], 2'b00}
//   Handshake rules:
//     - imem_ack outside FETCH is ignored.
//     - Minimum fetch-to-fetch period is 2 cycles (ack in first FETCH cycle).
//   Reset mid-fetch: request abandoned; imem_req low the cycle after rst is sampled.
//   Late acks after reset are ignored until the next FETCH.
//   Control_Unit outputs are valid for pc update only while inst_valid=1.
// CONFIGURATION
//   PC_ALIGN_CHECK_EN defined:
//     In EXEC, next_pc[1:0]!=0 (reachable only via jr) -> go ERROR, fetch_err<=1.
//     pc keeps the faulting instruction's address.
//   PC_ALIGN_CHECK_EN undefined:
//     next_pc[1:0] forced to 2'b00 before loading pc; no error raised.
// TESTING
//   1. rst=1 for 2 cycles, ack=0 -> pc=0, imem_req=0, inst_valid=0.
//      After release: IDLE, then imem_req=1 with addr 0.
//   2. Ack first FETCH cycle, rdata=0x2008_0005, pcsource=00 -> inst=0x2008_0005.
//      inst_valid high 1 cycle; pc 0->4; next imem_addr=4.
//   3. pc=0x10, inst=0x1000_FFFE, pcsource=01 -> pc=0x0000_000C.
//   4. pc=0x1000_0040, inst=0x0800_0100, pcsource=11 -> pc=0x1000_0400.
//      Separately: ra_data=0x200, pcsource=10 -> pc=0x200.
//   5. FETCH_TIMEOUT=16, ack never -> fetch_err=1 after 16th FETCH cycle.
//      imem_req=0 and stays 0; rst clears to reset values.
//      Ack on 16th cycle -> no error.
//   6. ra_data=0x202, pcsource=10:
//      with PC_ALIGN_CHECK_EN -> fetch_err=1, pc unchanged.
//      without -> pc=0x200, fetch continues.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit_if
//  Description : Instruction-memory request/acknowledge port used by the
//                PC/fetch stage. The master issues the request and address;
//                the slave (memory) returns the instruction word with ack.
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ack
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ack
   );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit
//  Description : Program counter and instruction-fetch stage for the
//                single-cycle MIPS core. Fetches one instruction per
//                req/ack transaction, presents it for one execute cycle,
//                then loads the next PC selected by pcsource. A fetch that
//                waits FETCH_TIMEOUT cycles without ack sets a sticky error.
//  Options     : PC_ALIGN_CHECK_EN - when defined, a misaligned next PC
//                (only reachable via jr) raises the sticky error instead of
//                being silently word-aligned.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int          FETCH_TIMEOUT = 16
) (
   input  wire logic          clk,
   input  wire logic          rst,
   input  wire logic [1:0]    pcsource,
   input  wire logic [31:0]   ra_data,
   pc_fetch_unit_if.master    imem,
   output logic [31:0]        inst,
   output logic               inst_valid,
   output logic [31:0]        pc,
   output logic [31:0]        pc_plus4,
   output logic               fetch_err
);

   localparam int TCNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
   localparam logic [TCNT_W-1:0] c_TCNT_LAST = TCNT_W'(FETCH_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_ERROR = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [31:0]         r_pc;
   logic [31:0]         w_pc_nxt;
   logic [31:0]         r_inst;
   logic [31:0]         w_inst_nxt;
   logic [TCNT_W-1:0]   r_tcnt;
   logic [TCNT_W-1:0]   w_tcnt_nxt;
   logic                r_err;
   logic                w_err_nxt;

   logic [31:0]         w_pc_plus4;
   logic [31:0]         w_next_pc;
   logic [31:0]         w_br_off;

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_br_off   = {{14{r_inst[15]}}, r_inst[15:0], 2'b00};

   // Next-PC selection from the decoder's pcsource code; all sums wrap.
   always_comb begin
      w_next_pc = w_pc_plus4;
      case (pcsource)
         2'b00:   w_next_pc = w_pc_plus4;
         2'b01:   w_next_pc = w_pc_plus4 + w_br_off;
         2'b10:   w_next_pc = ra_data;
         default: w_next_pc = {w_pc_plus4[31:28], r_inst[25:0], 2'b00};
      endcase
   end

   // State and datapath registers; reset puts the stage back to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_inst  <= 32'h0;
         r_tcnt  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_inst  <= w_inst_nxt;
         r_tcnt  <= w_tcnt_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // Fetch FSM next-state logic; ack beats the timeout in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_inst_nxt  = r_inst;
      w_tcnt_nxt  = r_tcnt;
      w_err_nxt   = r_err;
      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_FETCH;
            w_tcnt_nxt  = '0;
         end
         S_FETCH: begin
            if (imem.imem_ack) begin
               w_inst_nxt  = imem.imem_rdata;
               w_state_nxt = S_EXEC;
            end else if (r_tcnt == c_TCNT_LAST) begin
               w_state_nxt = S_ERROR;
               w_err_nxt   = 1'b1;
            end else begin
               w_tcnt_nxt  = r_tcnt + 1'b1;
            end
         end
         S_EXEC: begin
            w_tcnt_nxt = '0;
`ifdef PC_ALIGN_CHECK_EN
            // Faulting target: keep pc at the offending instruction.
            if (w_next_pc[1:0] != 2'b00) begin
               w_state_nxt = S_ERROR;
               w_err_nxt   = 1'b1;
            end else begin
               w_pc_nxt    = w_next_pc;
               w_state_nxt = S_FETCH;
            end
`else
            w_pc_nxt    = w_next_pc & ~32'h3;
            w_state_nxt = S_FETCH;
`endif
         end
         default: begin
            w_state_nxt = S_ERROR;
         end
      endcase
   end

   assign imem.imem_req  = (r_state == S_FETCH);
   assign imem.imem_addr = r_pc;
   assign inst           = r_inst;
   assign inst_valid     = (r_state == S_EXEC);
   assign pc             = r_pc;
   assign pc_plus4       = w_pc_plus4;
   assign fetch_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_unit
//  Description : Directed self-checking bench for pc_fetch_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_fetch_unit;

   logic        clk;
   logic        rst;
   logic [1:0]  pcsource;
   logic [31:0] ra_data;
   logic [31:0] inst;
   logic        inst_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_err;

   int n_chk;
   int n_pass;

   pc_fetch_unit_if u_if ();

   pc_fetch_unit #(
      .RESET_PC      (32'h0000_0000),
      .FETCH_TIMEOUT (16)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .pcsource   (pcsource),
      .ra_data    (ra_data),
      .imem       (u_if),
      .inst       (inst),
      .inst_valid (inst_valid),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .fetch_err  (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called while in FETCH: waits 'stall' cycles, acks with rdata, executes
   // with the given pcsource/ra_data and checks the resulting fetch address.
   task automatic fetch_exec(input string tag, input int stall, input logic [31:0] rdata,
                             input logic [1:0] sel, input logic [31:0] ra,
                             input logic [31:0] exp_pc);
      logic [31:0] a0;
      a0 = u_if.imem_addr;
      for (int i = 0; i < stall; i++) step();
      if (stall > 0) chk({tag, "_addr_stable"}, u_if.imem_addr, a0);
      u_if.imem_ack   = 1'b1;
      u_if.imem_rdata = rdata;
      step();
      u_if.imem_ack   = 1'b0;
      u_if.imem_rdata = 32'hDEAD_BEEF;
      chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
      chk({tag, "_inst"}, inst, rdata);
      pcsource = sel;
      ra_data  = ra;
      step();
      pcsource = 2'b00;
      ra_data  = 32'h0;
      chk({tag, "_valid_off"}, {31'd0, inst_valid}, 32'd0);
      chk({tag, "_pc"}, pc, exp_pc);
      chk({tag, "_addr"}, u_if.imem_addr, exp_pc);
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      rst = 1'b1;
      pcsource = 2'b00;
      ra_data = 32'h0;
      u_if.imem_ack = 1'b0;
      u_if.imem_rdata = 32'h0;

      // Reset state
      step();
      step();
      chk("rst_pc", pc, 32'h0);
      chk("rst_req", {31'd0, u_if.imem_req}, 32'd0);
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_err", {31'd0, fetch_err}, 32'd0);
      chk("rst_pc4", pc_plus4, 32'h4);
      rst = 1'b0;
      chk("idle_req", {31'd0, u_if.imem_req}, 32'd0);
      step();
      chk("fetch_req", {31'd0, u_if.imem_req}, 32'd1);
      chk("fetch_addr", u_if.imem_addr, 32'h0);

      // Sequential, then branch backward, jump, jr, forward branch
      fetch_exec("seq", 0, 32'h2008_0005, 2'b00, 32'h0, 32'h0000_0004);
      fetch_exec("jr10", 2, 32'h0000_0008, 2'b10, 32'h10, 32'h0000_0010);
      fetch_exec("br_back", 0, 32'h1000_FFFE, 2'b01, 32'h0, 32'h0000_000C);
      fetch_exec("jr_hi", 0, 32'h0, 2'b10, 32'h1000_0040, 32'h1000_0040);
      chk("pc4_hi", pc_plus4, 32'h1000_0044);
      fetch_exec("jmp", 0, 32'h0800_0100, 2'b11, 32'h0, 32'h1000_0400);
      fetch_exec("jr200", 1, 32'h0, 2'b10, 32'h200, 32'h0000_0200);
      fetch_exec("br_fwd", 0, 32'h1000_0003, 2'b01, 32'h0, 32'h0000_0210);

      // Misaligned jr target
`ifdef PC_ALIGN_CHECK_EN
      u_if.imem_ack = 1'b1;
      u_if.imem_rdata = 32'h0;
      step();
      u_if.imem_ack = 1'b0;
      pcsource = 2'b10;
      ra_data = 32'h202;
      step();
      chk("align_err", {31'd0, fetch_err}, 32'd1);
      chk("align_pc", pc, 32'h0000_0210);
      chk("align_req", {31'd0, u_if.imem_req}, 32'd0);
      pcsource = 2'b00;
`else
      fetch_exec("jr_mis", 0, 32'h0, 2'b10, 32'h202, 32'h0000_0200);
      chk("mis_err", {31'd0, fetch_err}, 32'd0);
      chk("mis_req", {31'd0, u_if.imem_req}, 32'd1);
`endif

      // Reset mid-activity; ack on 16th FETCH cycle must not time out
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst2_req", {31'd0, u_if.imem_req}, 32'd0);
      chk("rst2_pc", pc, 32'h0);
      chk("rst2_err", {31'd0, fetch_err}, 32'd0);
      step();
      fetch_exec("ack16", 15, 32'h0000_0020, 2'b00, 32'h0, 32'h0000_0004);
      chk("ack16_err", {31'd0, fetch_err}, 32'd0);

      // No ack: error after the 16th FETCH cycle
      for (int i = 0; i < 15; i++) step();
      chk("to15_err", {31'd0, fetch_err}, 32'd0);
      chk("to15_req", {31'd0, u_if.imem_req}, 32'd1);
      step();
      chk("to16_err", {31'd0, fetch_err}, 32'd1);
      chk("to16_req", {31'd0, u_if.imem_req}, 32'd0);
      // Late ack in ERROR is ignored; state frozen
      u_if.imem_ack = 1'b1;
      u_if.imem_rdata = 32'h1234_5678;
      step();
      step();
      u_if.imem_ack = 1'b0;
      chk("err_req", {31'd0, u_if.imem_req}, 32'd0);
      chk("err_inst", inst, 32'h0000_0020);
      chk("err_pc", pc, 32'h0000_0004);
      chk("err_valid", {31'd0, inst_valid}, 32'd0);
      chk("err_sticky", {31'd0, fetch_err}, 32'd1);

      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("clr_err", {31'd0, fetch_err}, 32'd0);
      chk("clr_pc", pc, 32'h0);
      chk("clr_inst", inst, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
